// File: rtl/reset_responder.sv
// Reset responder: turns a qualified upstream reset request into a timed local
// reset, then waits for lock/settle before reporting done.
module reset_responder #(
  parameter int unsigned CW = 16,
  parameter int unsigned TW = 32
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          resetreq_i,
  input  logic          locked_i,
  input  logic [CW-1:0] minwidth_i,
  input  logic [CW-1:0] holdlength_i,
  input  logic [CW-1:0] settlelength_i,
  input  logic [TW-1:0] timeout_i,
  output logic          localreset_o,
  output logic          done_o,
  output logic          donestrobe_o,
  output logic          error_o,
  output logic          runt_o,
  output logic          lostlock_o,
  output logic          busy_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MEASURE  = 3'd1,
    S_HOLD     = 3'd2,
    S_WAITLOCK = 3'd3,
    S_SETTLE   = 3'd4,
    S_DONE     = 3'd5,
    S_FAIL     = 3'd6
  } state_e;

  localparam logic [CW-1:0] C_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0] T_ONE = {{(TW-1){1'b0}}, 1'b1};

  state_e        state_q, state_d;
  logic          resetreq_q;
  logic          armed_q, armed_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] scnt_q, scnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          runt_q, runt_d;
  logic          err_q, err_d;
  logic          lost_q, lost_d;
  logic          lreset_q;
  logic          done_q;
  logic          dstb_q;
  logic          busy_q;

  logic          rise;
  logic          fall;
  logic [CW-1:0] hold_max;
  logic [TW-1:0] tcnt_inc;
  logic          tout_hit;
  logic          settled;

  // A request already high when reset lifts must be seen low before it counts.
  assign armed_d  = armed_q | ~resetreq_i;
  assign rise     = resetreq_i & ~resetreq_q & armed_q;
  assign fall     = ~resetreq_i & resetreq_q;

  assign hold_max = (holdlength_i == '0) ? C_ONE : holdlength_i;
  assign tcnt_inc = (&tcnt_q) ? tcnt_q : tcnt_q + T_ONE;
  assign tout_hit = (timeout_i != '0) && (tcnt_q == timeout_i);
  assign settled  = ({1'b0, scnt_q} + {1'b0, C_ONE})
                    >= {1'b0, settlelength_i};

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    hcnt_d  = hcnt_q;
    scnt_d  = scnt_q;
    tcnt_d  = tcnt_q;
    runt_d  = runt_q;
    err_d   = err_q;
    lost_d  = lost_q;
    if (rise) begin
      state_d = S_MEASURE;
      wcnt_d  = C_ONE;
      runt_d  = 1'b0;
      err_d   = 1'b0;
      lost_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_MEASURE: begin
          if (fall) begin
            if (wcnt_q >= minwidth_i) begin
              state_d = S_HOLD;
              hcnt_d  = C_ONE;
            end else begin
              state_d = S_IDLE;
              runt_d  = 1'b1;
            end
          end else if (resetreq_i && !(&wcnt_q)) begin
            wcnt_d = wcnt_q + C_ONE;
          end
        end
        S_HOLD: begin
          if (hcnt_q >= hold_max) begin
            state_d = S_WAITLOCK;
            tcnt_d  = '0;
          end else begin
            hcnt_d = hcnt_q + C_ONE;
          end
        end
        S_WAITLOCK: begin
          tcnt_d = tcnt_inc;
          if (locked_i) begin
            if (settlelength_i == '0) begin
              state_d = S_DONE;
            end else begin
              state_d = S_SETTLE;
              scnt_d  = '0;
            end
          end else if (tout_hit) begin
            state_d = S_FAIL;
            err_d   = 1'b1;
          end
        end
        S_SETTLE: begin
          tcnt_d = tcnt_inc;
          if (locked_i && settled) begin
            state_d = S_DONE;
          end else if (tout_hit) begin
            state_d = S_FAIL;
            err_d   = 1'b1;
          end else if (!locked_i) begin
            state_d = S_WAITLOCK;
          end else begin
            scnt_d = scnt_q + C_ONE;
          end
        end
        S_DONE: begin
          if (!locked_i) begin
            state_d = S_WAITLOCK;
            lost_d  = 1'b1;
            tcnt_d  = '0;
          end
        end
        S_IDLE, S_FAIL: begin
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      resetreq_q <= 1'b0;
      armed_q    <= 1'b0;
      wcnt_q     <= '0;
      hcnt_q     <= '0;
      scnt_q     <= '0;
      tcnt_q     <= '0;
      runt_q     <= 1'b0;
      err_q      <= 1'b0;
      lost_q     <= 1'b0;
      lreset_q   <= 1'b0;
      done_q     <= 1'b0;
      dstb_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      resetreq_q <= resetreq_i;
      armed_q    <= armed_d;
      wcnt_q     <= wcnt_d;
      hcnt_q     <= hcnt_d;
      scnt_q     <= scnt_d;
      tcnt_q     <= tcnt_d;
      runt_q     <= runt_d;
      err_q      <= err_d;
      lost_q     <= lost_d;
      lreset_q   <= (state_d == S_HOLD);
      done_q     <= (state_d == S_DONE);
      dstb_q     <= (state_d == S_DONE) && (state_q != S_DONE);
      busy_q     <= state_d inside
                    {S_MEASURE, S_HOLD, S_WAITLOCK, S_SETTLE};
    end
  end

  assign localreset_o = lreset_q;
  assign done_o       = done_q;
  assign donestrobe_o = dstb_q;
  assign error_o      = err_q;
  assign runt_o       = runt_q;
  assign lostlock_o   = lost_q;
  assign busy_o       = busy_q;

endmodule

// File: doc/reset_responder.md
RESET_RESPONDER -- requirements
Module: reset_responder

Interface
REQ-001 Parameter: CW, default 16, width of minwidth/holdlength/settlelength and of internal short counters.
REQ-002 Parameter: TW, default 32, width of timeout and of the timeout counter.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 resetreq  input  1  reset request pulse from the upstream chain sequencer (its resetout bit).
REQ-006 locked  input  1  local "initialized" status (PLL lock, calibration done, etc.), synchronous to clk.
REQ-007 minwidth  input  CW  minimum accepted resetreq high width, in cycles.
REQ-008 holdlength  input  CW  localreset assertion length, in cycles; 0 is treated as 1.
REQ-009 settlelength  input  CW  consecutive locked cycles required before done; 0 means done on first locked cycle.
REQ-010 timeout  input  TW  cycles allowed from HOLD exit to done; 0 disables the timeout.
REQ-011 localreset  output  1  reset to local logic.
REQ-012 done  output  1  level; drives the sequencer's donecriteria bit.
REQ-013 donestrobe  output  1  one-cycle pulse on each entry to DONE.
REQ-014 error  output  1  sticky timeout flag.
REQ-015 runt  output  1  sticky flag: a resetreq pulse shorter than minwidth was rejected.
REQ-016 lostlock  output  1  sticky flag: locked fell while in DONE.
REQ-017 busy  output  1  high in MEASURE, HOLD, WAITLOCK and SETTLE.

Function
REQ-018 resetreq is registered once (resetreq_r); rise = resetreq & ~resetreq_r, fall = ~resetreq & resetreq_r.
REQ-019 States: IDLE, MEASURE, HOLD, WAITLOCK, SETTLE, DONE, FAIL; 3-bit encoding; the state register updates every cycle.
REQ-020 rise in any state forces MEASURE on the next cycle, loads the width counter with 1, and clears done, error, runt and lostlock; rise has priority over every other transition.
REQ-021 MEASURE: width counter increments once per cycle while resetreq=1 and saturates at all-ones.
REQ-022 MEASURE on fall: if width counter >= minwidth, go to HOLD; otherwise go to IDLE and set runt.
REQ-023 HOLD: localreset=1 for exactly max(holdlength,1) cycles, then go to WAITLOCK; the timeout counter is cleared on HOLD exit.
REQ-024 WAITLOCK: when locked=1, go to SETTLE with the settle counter cleared; if timeout!=0 and timeout counter == timeout, go to FAIL; locked takes priority over timeout on the same cycle.
REQ-025 SETTLE: the settle counter increments while locked=1; when it reaches settlelength, go to DONE; if locked=0, return to WAITLOCK; the timeout check of REQ-024 also applies in SETTLE.
REQ-026 The timeout counter runs continuously through WAITLOCK and SETTLE, increments by 1 per cycle, and saturates; it is not cleared on SETTLE->WAITLOCK.
REQ-027 DONE: done=1; donestrobe=1 only on the first DONE cycle; if locked=0, set lostlock, clear done, restart the timeout counter and go to WAITLOCK.
REQ-028 FAIL: error=1; remain in FAIL until rise.
REQ-029 Outputs are registered and Moore-decoded from the registered state: localreset=(state==HOLD), done=(state==DONE), busy per REQ-017.
REQ-030 Timing: fall sampled at cycle t puts HOLD at t+1, so localreset is high on cycles t+1..t+max(holdlength,1).
REQ-031 A resetreq held high indefinitely keeps the block in MEASURE with localreset=0.
REQ-032 Counter comparisons are unsigned at full width with no truncation.

Reset
REQ-033 On reset: state=IDLE, resetreq_r=0, all counters=0, and localreset, done, donestrobe, error, runt, lostlock and busy are all 0.
REQ-034 Reset asserted mid-operation returns the block to the REQ-033 state immediately (asynchronously); a resetreq that is high at reset release is not treated as a rise until it is first seen low.

Verification
REQ-035 minwidth=4, holdlength=10, settlelength=3, timeout=100; resetreq high for 5 cycles; locked rises 20 cycles after HOLD exit -> localreset high for exactly 10 cycles, then done=1 with a single donestrobe 3 cycles after locked rises (settle counter reaches 3), error=0.
REQ-036 minwidth=4; resetreq high for 3 cycles -> runt=1, localreset never asserts, state returns to IDLE.
REQ-037 timeout=50; locked held 0 -> error=1 exactly 50 cycles after HOLD exit, done=0; a new valid pulse clears error and the sequence restarts.
REQ-038 settlelength=8; locked glitches low in cycle 5 of SETTLE -> returns to WAITLOCK, timeout counter not cleared, done deferred until 8 clean locked cycles.
REQ-039 In DONE, drop locked for 1 cycle -> lostlock=1, done=0, back in WAITLOCK; a second resetreq rise during HOLD restarts MEASURE with flags cleared.
REQ-040 Assert reset during HOLD -> localreset=0 immediately and all outputs 0; with resetreq high across reset release, no MEASURE entry occurs until resetreq toggles low then high.
